mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv_mem_pkg.sv | 28 ++
 rtl/bus_timeout_counter.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared constants and types for the memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_timeout_counter
//  Description : Counts busy cycles; flags the cycle the count reaches LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int LIMIT = 255,
    parameter int WIDTH = $clog2(LIMIT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted in the busy cycle whose closing edge makes the count equal LIMIT.
    assign expire_o = enable_i & ~clear_i & (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing one memory port between fetch
//                and data requesters, with transaction timeout abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic [31:0] d_rdata,
    output logic        d_done,

    output logic        if_stall,
    output logic        d_stall,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_funct3,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,

    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic        m_req_q, m_req_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_done_q, if_done_d;
    logic        d_done_q, d_done_d;
    logic        bus_err_q, bus_err_d;

    logic        if_elig;
    logic        d_elig;
    logic        sel_fetch;
    logic        sel_data;
    logic        busy;
    logic        expire;

    // A requester still holding req during its done cycle must not be regranted.
    assign if_elig = if_req & ~if_done_q;
    assign d_elig  = d_req  & ~d_done_q;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        sel_fetch = 1'b0;
        sel_data  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (if_elig && d_elig) begin
                if (last_grant_q == GRANT_FETCH) begin
                    sel_data = 1'b1;
                end else begin
                    sel_fetch = 1'b1;
                end
            end else if (if_elig) begin
                sel_fetch = 1'b1;
            end else if (d_elig) begin
                sel_data = 1'b1;
            end
        end
    end

    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (CNT_W)
    ) u_timeout (
        .clk_i    (clk),
        .rst_ni   (reset),
        .clear_i  (sel_fetch | sel_data),
        .enable_i (busy),
        .expire_o (expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        m_req_d      = m_req_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_fetch) begin
                    state_d      = ST_BUSY_I;
                    last_grant_d = GRANT_FETCH;
                    m_req_d      = 1'b1;
                    cmd_d.we     = 1'b0;
                    cmd_d.addr   = if_addr;
                    cmd_d.wdata  = 32'd0;
                    cmd_d.funct3 = FETCH_FUNCT3;
                end else if (sel_data) begin
                    state_d      = ST_BUSY_D;
                    last_grant_d = GRANT_DATA;
                    m_req_d      = 1'b1;
                    cmd_d.we     = d_we;
                    cmd_d.addr   = d_addr;
                    cmd_d.wdata  = d_wdata;
                    cmd_d.funct3 = d_funct3;
                end
            end

            ST_BUSY_I: begin
                // m_ready wins over a simultaneous expiry.
                if (m_ready) begin
                    if_rdata_d = m_rdata;
                    if_done_d  = 1'b1;
                    m_req_d    = 1'b0;
                    state_d    = ST_IDLE;
                end else if (expire) begin
                    if_rdata_d = 32'd0;
                    if_done_d  = 1'b1;
                    bus_err_d  = 1'b1;
                    m_req_d    = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            ST_BUSY_D: begin
                if (m_ready) begin
                    if (!cmd_q.we) begin
                        d_rdata_d = m_rdata;
                    end
                    d_done_d = 1'b1;
                    m_req_d  = 1'b0;
                    state_d  = ST_IDLE;
                end else if (expire) begin
                    if (!cmd_q.we) begin
                        d_rdata_d = 32'd0;
                    end
                    d_done_d  = 1'b1;
                    bus_err_d = 1'b1;
                    m_req_d   = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_FETCH;
            cmd_q        <= '0;
            m_req_q      <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            m_req_q      <= m_req_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = cmd_q.we;
    assign m_addr   = cmd_q.addr;
    assign m_wdata  = cmd_q.wdata;
    assign m_funct3 = cmd_q.funct3;

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign bus_err  = bus_err_q;

    assign if_stall = if_req & ~if_done_q;
    assign d_stall  = d_req  & ~d_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter (timeout 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_funct3 = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        if_stall;
    logic        d_stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_funct3;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_rdata(d_rdata), .d_done(d_done),
        .if_stall(if_stall), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_funct3(m_funct3), .m_ready(m_ready), .m_rdata(m_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(); tick();
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req: got %0b want 0", m_req); end
        checks++; if ({if_done, d_done, bus_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {if_done, d_done, bus_err}); end
        checks++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
        checks++; if (m_addr !== 32'd0 || m_wdata !== 32'd0 || m_we !== 1'b0 || m_funct3 !== 3'd0) begin
            errors++; $display("FAIL rst_mport: got addr=%h wdata=%h we=%0b f3=%0d want zeros", m_addr, m_wdata, m_we, m_funct3);
        end
        reset = 1'b1;
        tick();
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_idle: got m_req=%0b want 0", m_req); end
    endtask

    task automatic test_tie();
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_funct3 = 3'b010;
        tick();
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h2000) begin errors++; $display("FAIL tie1_data_first: got req=%0b addr=%h want 1/00002000", m_req, m_addr); end
        checks++; if (if_stall !== 1'b1 || d_stall !== 1'b1) begin errors++; $display("FAIL tie1_stalls: got %0b%0b want 11", if_stall, d_stall); end
        m_ready = 1'b1; m_rdata = 32'h11112222;
        tick();
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h11112222 || m_req !== 1'b0) begin
            errors++; $display("FAIL tie1_done: got done=%0b rdata=%h req=%0b want 1/11112222/0", d_done, d_rdata, m_req);
        end
        checks++; if (d_stall !== 1'b0) begin errors++; $display("FAIL tie1_dstall: got %0b want 0", d_stall); end
        m_ready = 1'b0; if_req = 1'b0;
        tick();
        checks++; if (m_req !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL no_regrant: got req=%0b done=%0b want 0/0", m_req, d_done); end
        if_req = 1'b1;
        tick();
        checks++; if (m_addr !== 32'h200 || m_funct3 !== 3'b010 || m_we !== 1'b0 || m_req !== 1'b1) begin
            errors++; $display("FAIL tie2_fetch_first: got addr=%h f3=%0d we=%0b req=%0b want 00000200/2/0/1", m_addr, m_funct3, m_we, m_req);
        end
        m_ready = 1'b1; m_rdata = 32'h33334444;
        tick();
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h33334444) begin errors++; $display("FAIL tie2_fetch_done: got %0b/%h want 1/33334444", if_done, if_rdata); end
        m_ready = 1'b0; if_req = 1'b0;
        tick();
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h2000) begin errors++; $display("FAIL tie2_data_after: got req=%0b addr=%h want 1/00002000", m_req, m_addr); end
        m_ready = 1'b1; m_rdata = 32'h55556666;
        tick();
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h55556666) begin errors++; $display("FAIL tie2_data_done: got %0b/%h want 1/55556666", d_done, d_rdata); end
        m_ready = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0 || m_wdata !== 32'd0 || m_funct3 !== 3'b010) begin
            errors++; $display("FAIL fetch_grant: got req=%0b addr=%h we=%0b wd=%h f3=%0d want 1/00000100/0/0/2", m_req, m_addr, m_we, m_wdata, m_funct3);
        end
        checks++; if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %0b want 1", if_stall); end
        if_addr = 32'h104;
        tick(); tick(); tick();
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h100 || if_done !== 1'b0) begin
            errors++; $display("FAIL fetch_hold: got req=%0b addr=%h done=%0b want 1/00000100/0", m_req, m_addr, if_done);
        end
        m_ready = 1'b1; m_rdata = 32'h00500093;
        tick();
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h00500093 || if_stall !== 1'b0) begin
            errors++; $display("FAIL fetch_done: got done=%0b rdata=%h stall=%0b want 1/00500093/0", if_done, if_rdata, if_stall);
        end
        checks++; if (bus_err !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL fetch_clean: got err=%0b req=%0b want 0/0", bus_err, m_req); end
        m_ready = 1'b0;
        tick();
        checks++; if (if_done !== 1'b0 || m_req !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got done=%0b req=%0b want 0/0", if_done, m_req); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        tick();
        checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'hDEADBEEF || m_funct3 !== 3'b010) begin
            errors++; $display("FAIL store_grant: got req=%0b we=%0b addr=%h wd=%h f3=%0d want 1/1/00000040/deadbeef/2", m_req, m_we, m_addr, m_wdata, m_funct3);
        end
        d_addr = 32'h999; d_wdata = 32'd0;
        tick(); tick();
        checks++; if (m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_hold: got we=%0b addr=%h wd=%h want 1/00000040/deadbeef", m_we, m_addr, m_wdata);
        end
        m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
        tick();
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h55556666) begin
            errors++; $display("FAIL store_done: got done=%0b rdata=%h want 1/55556666", d_done, d_rdata);
        end
        m_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_funct3 = 3'b010;
        tick();
        tick(); tick(); tick();
        checks++; if (bus_err !== 1'b0 || m_req !== 1'b1) begin errors++; $display("FAIL to_early: got err=%0b req=%0b want 0/1", bus_err, m_req); end
        tick();
        checks++; if (bus_err !== 1'b1 || d_done !== 1'b1) begin errors++; $display("FAIL to_abort: got err=%0b done=%0b want 1/1", bus_err, d_done); end
        checks++; if (d_rdata !== 32'd0 || m_req !== 1'b0) begin errors++; $display("FAIL to_state: got rdata=%h req=%0b want 0/0", d_rdata, m_req); end
        d_req = 1'b0;
        tick();
        checks++; if (bus_err !== 1'b0 || d_done !== 1'b0 || m_req !== 1'b0) begin
            errors++; $display("FAIL to_pulse: got err=%0b done=%0b req=%0b want 0/0/0", bus_err, d_done, m_req);
        end
    endtask

    task automatic test_exact_timeout();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3004;
        tick();
        tick(); tick(); tick();
        m_ready = 1'b1; m_rdata = 32'hA5A5A5A5;
        tick();
        checks++; if (d_done !== 1'b1 || bus_err !== 1'b0 || d_rdata !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL exact_to: got done=%0b err=%0b rdata=%h want 1/0/a5a5a5a5", d_done, bus_err, d_rdata);
        end
        m_ready = 1'b0; d_req = 1'b0;
        tick();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL exact_to_late: got err=%0b want 0", bus_err); end
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL midrst_async: got m_req=%0b want 0", m_req); end
        m_ready = 1'b1; m_rdata = 32'h77;
        tick();
        checks++; if (d_done !== 1'b0 || bus_err !== 1'b0 || d_rdata !== 32'd0) begin
            errors++; $display("FAIL midrst_silent: got done=%0b err=%0b rdata=%h want 0/0/0", d_done, bus_err, d_rdata);
        end
        m_ready = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h500) begin errors++; $display("FAIL midrst_regrant: got req=%0b addr=%h want 1/00000500", m_req, m_addr); end
        m_ready = 1'b1; m_rdata = 32'h12345678;
        tick();
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h12345678) begin errors++; $display("FAIL midrst_done: got %0b/%h want 1/12345678", d_done, d_rdata); end
        m_ready = 1'b0; d_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_fetch();
        test_store();
        test_timeout();
        test_exact_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
